vreg_xbar_burst: RTL and testbench
==================================

Name: vreg_xbar_burst

Overview:
- Second-generation port-to-vector-register crossbar: NUM_PORT lane ports to NUM_BANK vector-register banks.
- Each bank has its own round-robin arbiter with burst locking. A winning port keeps the bank for its full access length, so beats of a multi-element vector access are never interleaved with another port's beats.
- Per-beat valid/ready handshake replaces fire-and-forget requests.
- Read data and write acks return to the issuing port with fixed 1-cycle latency.

Parameters:
- NUM_PORT, 4, number of requesting lane ports.
- NUM_BANK, 8, number of vector register banks.
- ADDR_W, 6, element address width (register depth 64).
- DATA_W, 64, element data width.
- LEN_W, 4, burst length field width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_vld  in  NUM_PORT  per-port beat valid.
- req_rdy  out  NUM_PORT  per-port beat accepted (combinational).
- req_bank  in  NUM_PORT*$clog2(NUM_BANK)  target bank per port.
- req_we  in  NUM_PORT  1=write, 0=read.
- req_addr  in  NUM_PORT*ADDR_W  element address of this beat.
- req_wdata  in  NUM_PORT*DATA_W  write data.
- req_len  in  NUM_PORT*LEN_W  burst beats; 0 treated as 1; sampled on first beat only.
- bank_rd_en  out  NUM_BANK  read strobe.
- bank_we  out  NUM_BANK  write strobe.
- bank_addr  out  NUM_BANK*ADDR_W  read/write address.
- bank_wdata  out  NUM_BANK*DATA_W  write data.
- bank_rdata  in  NUM_BANK*DATA_W  bank read data, valid 1 cycle after bank_rd_en.
- rsp_vld  out  NUM_PORT  response valid (read data or write ack).
- rsp_we  out  NUM_PORT  1=write ack, 0=read data.
- rsp_bank  out  NUM_PORT*$clog2(NUM_BANK)  bank that served the beat.
- rsp_rdata  out  NUM_PORT*DATA_W  read data; 0 for write ack.

Behaviour:
- Per-bank state: IDLE / LOCKED. Each bank holds owner[$clog2(NUM_PORT)], remaining[LEN_W] and rr_ptr.
- IDLE arbitration: the candidate set is ports with req_vld && req_bank==b that do not hold a lock on any bank.
  - Winner = first candidate at or after rr_ptr, circular search.
  - The winner's req_rdy rises in the same cycle, so the first beat is accepted with zero wait.
- Burst length L = max(req_len,1), taken from the winner's first beat.
  - If L==1: stay IDLE and set rr_ptr=winner+1 mod NUM_PORT.
  - Else: go to LOCKED with owner=winner, remaining=L-1.
- LOCKED:
  - Only the owner is eligible. req_rdy[owner] = req_vld[owner] && req_bank[owner]==b.
  - Each accepted beat decrements remaining. On the beat where remaining==1, go to IDLE and set rr_ptr=owner+1.
  - If the owner drops req_vld, the bank idles but stays locked; no other port is granted.
- A locked owner presenting a different bank gets req_rdy=0 (no cross-bank grant mid-burst).
- Bank drive on an accepted beat:
  - bank_rd_en = !req_we; bank_we = req_we.
  - bank_addr and bank_wdata come from the granted port.
  - With no accepted beat, all strobes are 0 and bank_addr/bank_wdata hold 0.
- Response, fixed 1-cycle latency: an accepted beat at cycle T gives rsp_vld=1 at T+1, with rsp_we and rsp_bank registered.
  - rsp_rdata = bank_rdata[rsp_bank] muxed combinationally from the registered bank index; 0 when rsp_we=1.
- At most one beat per port per cycle and one per bank per cycle. Full throughput: a back-to-back burst of L beats completes in L cycles.
- Reset (synchronous, including mid-burst):
  - All banks go to IDLE with owner=0, remaining=0, rr_ptr=0.
  - rsp_vld=0, rsp_we=0, rsp_bank=0.
  - While reset is high, req_rdy=0 and all bank strobes are 0.
  - An aborted burst is discarded; no response is issued for it after reset.

Optional Feature:
- Macro XBAR_LOCK_TIMEOUT_EN.
- Defined: each LOCKED bank has an idle counter, parameter LOCK_TIMEOUT, default 16.
  - The counter increments on each cycle with no accepted beat and clears on every accepted beat.
  - On reaching LOCK_TIMEOUT, the bank returns to IDLE, rr_ptr=owner+1, and the remaining beats are abandoned.
  - The owner's later beats then re-arbitrate as a new burst.
- Undefined: the lock is held indefinitely until the burst completes or reset.

Test Plan:
- Port0 writes bank3, len=4, four back-to-back beats with addr 0..3 -> bank_we[3]=1 for 4 consecutive cycles, bank_addr 0,1,2,3; rsp_vld[0] with rsp_we=1 for 4 cycles, each 1 cycle later.
- Ports 0,1,2 each request bank5 with len=1, held continuously from reset -> grants go 0,1,2,0,... one per cycle; req_rdy is one-hot each cycle.
- Port1 reads bank2 len=3; port0 requests bank2 during the burst -> port0 req_rdy=0 until port1's 3rd beat; port0 is granted the next cycle.
- Port2 reads bank1 addr 7 with bank_rdata[1]=0xDEAD_BEEF on the following cycle -> rsp_vld[2]=1, rsp_bank=1, rsp_rdata=0xDEAD_BEEF exactly 1 cycle after acceptance.
- Reset asserted after 2 of 4 beats of port3's burst on bank0 -> next cycle bank0 is IDLE, no rsp_vld; a fresh len=1 from port1 is granted immediately.
- (XBAR_LOCK_TIMEOUT_EN) Owner stalls 16 cycles mid-burst with another port waiting -> the waiting port is granted on cycle 17.

Source files
------------

// File: rtl/vreg_xbar_burst_if.sv
// rtl/vreg_xbar_burst_if.sv - request, bank and response bundle of the vector-register crossbar
//
// Purpose: groups every lane-port and bank-side signal of vreg_xbar_burst.
//   master modport: lane ports plus bank model (drives requests and bank_rdata)
//   slave modport : the crossbar itself
// Signals:
//   req_vld/req_rdy/req_bank/req_we/req_addr/req_wdata/req_len : per-port beat request
//   bank_rd_en/bank_we/bank_addr/bank_wdata/bank_rdata          : per-bank register access
//   rsp_vld/rsp_we/rsp_bank/rsp_rdata                            : per-port response
interface vreg_xbar_burst_if #(
  parameter int NUM_PORT = 4,
  parameter int NUM_BANK = 8,
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 64,
  parameter int LEN_W    = 4
);
  localparam int BANK_W = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;

  logic [NUM_PORT-1:0]          req_vld;
  logic [NUM_PORT-1:0]          req_rdy;
  logic [NUM_PORT*BANK_W-1:0]   req_bank;
  logic [NUM_PORT-1:0]          req_we;
  logic [NUM_PORT*ADDR_W-1:0]   req_addr;
  logic [NUM_PORT*DATA_W-1:0]   req_wdata;
  logic [NUM_PORT*LEN_W-1:0]    req_len;

  logic [NUM_BANK-1:0]          bank_rd_en;
  logic [NUM_BANK-1:0]          bank_we;
  logic [NUM_BANK*ADDR_W-1:0]   bank_addr;
  logic [NUM_BANK*DATA_W-1:0]   bank_wdata;
  logic [NUM_BANK*DATA_W-1:0]   bank_rdata;

  logic [NUM_PORT-1:0]          rsp_vld;
  logic [NUM_PORT-1:0]          rsp_we;
  logic [NUM_PORT*BANK_W-1:0]   rsp_bank;
  logic [NUM_PORT*DATA_W-1:0]   rsp_rdata;

  modport master (
    output req_vld, req_bank, req_we, req_addr, req_wdata, req_len,
    input  req_rdy,
    input  bank_rd_en, bank_we, bank_addr, bank_wdata,
    output bank_rdata,
    input  rsp_vld, rsp_we, rsp_bank, rsp_rdata
  );

  modport slave (
    input  req_vld, req_bank, req_we, req_addr, req_wdata, req_len,
    output req_rdy,
    output bank_rd_en, bank_we, bank_addr, bank_wdata,
    input  bank_rdata,
    output rsp_vld, rsp_we, rsp_bank, rsp_rdata
  );
endinterface

// File: rtl/vreg_xbar_burst.sv
// rtl/vreg_xbar_burst.sv - lane-port to vector-register-bank crossbar with burst-locking arbiters
//
// Purpose: routes NUM_PORT lane ports onto NUM_BANK register banks. Each bank runs a
//   round-robin arbiter; a winner with a multi-beat burst locks the bank until its last
//   beat so beats of one vector access are never interleaved. Responses (read data or
//   write ack) return to the issuing port exactly one cycle after acceptance.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high reset
//   bus   : vreg_xbar_burst_if.slave (requests, bank access, responses)
// Optional build macro: XBAR_LOCK_TIMEOUT_EN - a locked bank that sees LOCK_TIMEOUT
//   consecutive cycles without an accepted beat drops the lock and re-arbitrates.
module vreg_xbar_burst #(
  parameter int NUM_PORT = 4,
  parameter int NUM_BANK = 8,
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 64,
  parameter int LEN_W    = 4
`ifdef XBAR_LOCK_TIMEOUT_EN
  ,
  parameter int LOCK_TIMEOUT = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  vreg_xbar_burst_if.slave bus
);

  localparam int PORT_W = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;
  localparam int BANK_W = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;
`ifdef XBAR_LOCK_TIMEOUT_EN
  localparam int CNT_W  = $clog2(LOCK_TIMEOUT + 1);
`endif

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } bank_state_t;

  bank_state_t       state_q  [NUM_BANK];
  bank_state_t       state_d  [NUM_BANK];
  logic [PORT_W-1:0] owner_q  [NUM_BANK];
  logic [PORT_W-1:0] owner_d  [NUM_BANK];
  logic [LEN_W-1:0]  remain_q [NUM_BANK];
  logic [LEN_W-1:0]  remain_d [NUM_BANK];
  logic [PORT_W-1:0] rr_q     [NUM_BANK];
  logic [PORT_W-1:0] rr_d     [NUM_BANK];
`ifdef XBAR_LOCK_TIMEOUT_EN
  logic [CNT_W-1:0]  cnt_q    [NUM_BANK];
  logic [CNT_W-1:0]  cnt_d    [NUM_BANK];
`endif

  logic [NUM_BANK-1:0] gnt_vld;
  logic [PORT_W-1:0]   gnt_port [NUM_BANK];
  logic [NUM_PORT-1:0] port_locked;

  logic [NUM_PORT-1:0] rsp_vld_q;
  logic [NUM_PORT-1:0] rsp_we_q;
  logic [BANK_W-1:0]   rsp_bank_q [NUM_PORT];

  function automatic logic [PORT_W-1:0] next_port(input logic [PORT_W-1:0] p);
    if (p == PORT_W'(NUM_PORT - 1)) begin
      return '0;
    end
    return p + PORT_W'(1);
  endfunction

  // A port mid-burst on one bank must not be granted by any other bank.
  always_comb begin
    port_locked = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      if (state_q[b] == S_LOCKED) begin
        port_locked[owner_q[b]] = 1'b1;
      end
    end
  end

  // Per-bank arbitration and next state.
  always_comb begin
    logic              found;
    logic [PORT_W-1:0] cand_port;
    logic [LEN_W-1:0]  first_len;
    int                idx;

    found     = 1'b0;
    cand_port = '0;
    first_len = '0;
    idx       = 0;

    for (int b = 0; b < NUM_BANK; b++) begin
      state_d[b]  = state_q[b];
      owner_d[b]  = owner_q[b];
      remain_d[b] = remain_q[b];
      rr_d[b]     = rr_q[b];
`ifdef XBAR_LOCK_TIMEOUT_EN
      cnt_d[b]    = cnt_q[b];
`endif
      gnt_vld[b]  = 1'b0;
      gnt_port[b] = '0;
    end

    for (int b = 0; b < NUM_BANK; b++) begin
      if (state_q[b] == S_IDLE) begin
        // Circular search starting at rr_q: first unlocked port asking for this bank.
        found     = 1'b0;
        cand_port = '0;
        for (int k = 0; k < NUM_PORT; k++) begin
          idx = (int'(rr_q[b]) + k) % NUM_PORT;
          if (!found && bus.req_vld[idx] && !port_locked[idx] &&
              bus.req_bank[idx*BANK_W +: BANK_W] == BANK_W'(b)) begin
            found     = 1'b1;
            cand_port = PORT_W'(idx);
          end
        end
        gnt_vld[b]  = found;
        gnt_port[b] = cand_port;
      end else begin
        // Locked: only the owner, and only while it points at this bank.
        gnt_vld[b]  = bus.req_vld[owner_q[b]] &&
                      (bus.req_bank[int'(owner_q[b])*BANK_W +: BANK_W] == BANK_W'(b));
        gnt_port[b] = owner_q[b];
      end

      if (reset) begin
        gnt_vld[b] = 1'b0;
      end

      if (gnt_vld[b]) begin
        first_len = bus.req_len[int'(gnt_port[b])*LEN_W +: LEN_W];
        if (state_q[b] == S_IDLE) begin
          // A length of 0 or 1 is a single beat and never locks the bank.
          if (first_len <= LEN_W'(1)) begin
            rr_d[b] = next_port(gnt_port[b]);
          end else begin
            state_d[b]  = S_LOCKED;
            owner_d[b]  = gnt_port[b];
            remain_d[b] = first_len - LEN_W'(1);
          end
        end else if (remain_q[b] == LEN_W'(1)) begin
          state_d[b]  = S_IDLE;
          remain_d[b] = '0;
          rr_d[b]     = next_port(owner_q[b]);
        end else begin
          remain_d[b] = remain_q[b] - LEN_W'(1);
        end
`ifdef XBAR_LOCK_TIMEOUT_EN
        cnt_d[b] = '0;
`endif
      end
`ifdef XBAR_LOCK_TIMEOUT_EN
      else if (state_q[b] == S_LOCKED) begin
        // The LOCK_TIMEOUT-th consecutive idle cycle releases the lock.
        if (cnt_q[b] == CNT_W'(LOCK_TIMEOUT - 1)) begin
          state_d[b]  = S_IDLE;
          remain_d[b] = '0;
          rr_d[b]     = next_port(owner_q[b]);
          cnt_d[b]    = '0;
        end else begin
          cnt_d[b] = cnt_q[b] + CNT_W'(1);
        end
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NUM_BANK; b++) begin
        state_q[b]  <= S_IDLE;
        owner_q[b]  <= '0;
        remain_q[b] <= '0;
        rr_q[b]     <= '0;
`ifdef XBAR_LOCK_TIMEOUT_EN
        cnt_q[b]    <= '0;
`endif
      end
    end else begin
      for (int b = 0; b < NUM_BANK; b++) begin
        state_q[b]  <= state_d[b];
        owner_q[b]  <= owner_d[b];
        remain_q[b] <= remain_d[b];
        rr_q[b]     <= rr_d[b];
`ifdef XBAR_LOCK_TIMEOUT_EN
        cnt_q[b]    <= cnt_d[b];
`endif
      end
    end
  end

  // Grant fan-out: handshake back to the port, access strobes out to the bank.
  always_comb begin
    bus.req_rdy    = '0;
    bus.bank_rd_en = '0;
    bus.bank_we    = '0;
    bus.bank_addr  = '0;
    bus.bank_wdata = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      if (gnt_vld[b]) begin
        bus.req_rdy[gnt_port[b]]              = 1'b1;
        bus.bank_we[b]                        = bus.req_we[gnt_port[b]];
        bus.bank_rd_en[b]                     = !bus.req_we[gnt_port[b]];
        bus.bank_addr[b*ADDR_W +: ADDR_W]     = bus.req_addr[int'(gnt_port[b])*ADDR_W +: ADDR_W];
        bus.bank_wdata[b*DATA_W +: DATA_W]    = bus.req_wdata[int'(gnt_port[b])*DATA_W +: DATA_W];
      end
    end
  end

  // req_rdy is only ever raised alongside req_vld, so it marks an accepted beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_vld_q <= '0;
      rsp_we_q  <= '0;
      for (int p = 0; p < NUM_PORT; p++) begin
        rsp_bank_q[p] <= '0;
      end
    end else begin
      rsp_vld_q <= bus.req_rdy;
      for (int p = 0; p < NUM_PORT; p++) begin
        if (bus.req_rdy[p]) begin
          rsp_we_q[p]   <= bus.req_we[p];
          rsp_bank_q[p] <= bus.req_bank[p*BANK_W +: BANK_W];
        end
      end
    end
  end

  // Read data arrives from the bank one cycle after the strobe, so it is picked up
  // combinationally using the bank index registered with the accepted beat.
  always_comb begin
    bus.rsp_vld   = rsp_vld_q;
    bus.rsp_we    = rsp_we_q;
    bus.rsp_bank  = '0;
    bus.rsp_rdata = '0;
    for (int p = 0; p < NUM_PORT; p++) begin
      bus.rsp_bank[p*BANK_W +: BANK_W] = rsp_bank_q[p];
      if (!rsp_we_q[p]) begin
        bus.rsp_rdata[p*DATA_W +: DATA_W] = bus.bank_rdata[int'(rsp_bank_q[p])*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_vreg_xbar_burst.sv
// tb/tb_vreg_xbar_burst.sv - self-checking bench for vreg_xbar_burst with a behavioural bank model
module tb_vreg_xbar_burst;
  localparam int NP = 4;
  localparam int NB = 8;
  localparam int AW = 6;
  localparam int DW = 64;
  localparam int LW = 4;
  localparam int BW = $clog2(NB);
`ifdef XBAR_LOCK_TIMEOUT_EN
  localparam int TMO = 16;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  vreg_xbar_burst_if #(.NUM_PORT(NP), .NUM_BANK(NB), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

  vreg_xbar_burst #(.NUM_PORT(NP), .NUM_BANK(NB), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Port-side stimulus and bank read data, packed onto the interface by step().
  logic          p_vld   [NP];
  int            p_bank  [NP];
  logic          p_we    [NP];
  logic [AW-1:0] p_addr  [NP];
  logic [DW-1:0] p_wdata [NP];
  int            p_len   [NP];
  logic [DW-1:0] b_rdata [NB];

  // Reference model: who owns each bank (-1 = free), beats still owed, next priority.
  int   own  [NB];
  int   left [NB];
  int   rr   [NB];
  int   idle [NB];
  logic e_rvld  [NP];
  logic e_rwe   [NP];
  int   e_rbank [NP];
  logic rsp_known = 1'b0;
  logic [NP-1:0] last_acc;

  // Snapshot of DUT outputs taken on the falling edge.
  logic [NP-1:0] o_rdy, o_rvld, o_rwe;
  logic [NB-1:0] o_we, o_rd;
  logic [AW-1:0] o_addr  [NB];
  int            o_rbank [NP];
  logic [DW-1:0] o_rdata [NP];

  int g_left [NP];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int b = 0; b < NB; b++) begin
      own[b] = -1; left[b] = 0; rr[b] = 0; idle[b] = 0;
    end
    for (int p = 0; p < NP; p++) begin
      e_rvld[p] = 1'b0; e_rwe[p] = 1'b0; e_rbank[p] = 0;
    end
  endfunction

  function automatic int model_grant(input int b);
    int  g, best_d, d;
    bit  busy;
    g = -1;
    best_d = NP;
    if (reset) return -1;
    if (own[b] >= 0) begin
      if (p_vld[own[b]] && p_bank[own[b]] == b) g = own[b];
    end else begin
      for (int p = 0; p < NP; p++) begin
        busy = 1'b0;
        for (int x = 0; x < NB; x++) if (own[x] == p) busy = 1'b1;
        d = (p - rr[b] + NP) % NP;
        if (p_vld[p] && p_bank[p] == b && !busy && d < best_d) begin
          best_d = d;
          g = p;
        end
      end
    end
    return g;
  endfunction

  task automatic idle_ports();
    for (int p = 0; p < NP; p++) begin
      p_vld[p] = 1'b0; p_bank[p] = 0; p_we[p] = 1'b0;
      p_addr[p] = '0; p_wdata[p] = '0; p_len[p] = 0;
    end
    for (int b = 0; b < NB; b++) b_rdata[b] = {$urandom, $urandom};
  endtask

  // One clock cycle: drive, compare against the model on the falling edge, advance the model.
  task automatic step();
    int            gp [NB];
    logic [NP-1:0] erdy, ervld;
    logic [NB-1:0] ewe, erd;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    int            len;
    for (int p = 0; p < NP; p++) begin
      bus.req_vld[p]                = p_vld[p];
      bus.req_bank[p*BW +: BW]      = BW'(p_bank[p]);
      bus.req_we[p]                 = p_we[p];
      bus.req_addr[p*AW +: AW]      = p_addr[p];
      bus.req_wdata[p*DW +: DW]     = p_wdata[p];
      bus.req_len[p*LW +: LW]       = LW'(p_len[p]);
    end
    for (int b = 0; b < NB; b++) bus.bank_rdata[b*DW +: DW] = b_rdata[b];

    @(negedge clk);
    o_rdy = bus.req_rdy; o_rvld = bus.rsp_vld; o_rwe = bus.rsp_we;
    o_we = bus.bank_we; o_rd = bus.bank_rd_en;
    for (int b = 0; b < NB; b++) o_addr[b] = bus.bank_addr[b*AW +: AW];
    for (int p = 0; p < NP; p++) begin
      o_rbank[p] = int'(bus.rsp_bank[p*BW +: BW]);
      o_rdata[p] = bus.rsp_rdata[p*DW +: DW];
    end

    erdy = '0; ewe = '0; erd = '0; ervld = '0;
    for (int b = 0; b < NB; b++) begin
      gp[b] = model_grant(b);
      if (gp[b] >= 0) begin
        erdy[gp[b]] = 1'b1;
        ewe[b] = p_we[gp[b]];
        erd[b] = !p_we[gp[b]];
      end
    end
    check("req_rdy", o_rdy, erdy);
    check("bank_we", o_we, ewe);
    check("bank_rd_en", o_rd, erd);
    for (int b = 0; b < NB; b++) begin
      ea = '0; ed = '0;
      if (gp[b] >= 0) begin
        ea = p_addr[gp[b]];
        ed = p_wdata[gp[b]];
      end
      check($sformatf("bank_addr[%0d]", b), o_addr[b], ea);
      check($sformatf("bank_wdata[%0d]", b), bus.bank_wdata[b*DW +: DW], ed);
    end

    if (rsp_known) begin
      for (int p = 0; p < NP; p++) ervld[p] = e_rvld[p];
      check("rsp_vld", o_rvld, ervld);
      for (int p = 0; p < NP; p++) begin
        if (e_rvld[p]) begin
          check($sformatf("rsp_we[%0d]", p), o_rwe[p], e_rwe[p]);
          check($sformatf("rsp_bank[%0d]", p), o_rbank[p], e_rbank[p]);
          check($sformatf("rsp_rdata[%0d]", p), o_rdata[p], e_rwe[p] ? '0 : b_rdata[e_rbank[p]]);
        end
      end
    end

    last_acc = erdy;
    if (reset) begin
      model_reset();
      rsp_known = 1'b1;
    end else begin
      for (int p = 0; p < NP; p++) begin
        e_rvld[p] = erdy[p];
        if (erdy[p]) begin
          e_rwe[p] = p_we[p];
          e_rbank[p] = p_bank[p];
        end
      end
      for (int b = 0; b < NB; b++) begin
        if (gp[b] >= 0) begin
          idle[b] = 0;
          if (own[b] < 0) begin
            len = (p_len[gp[b]] == 0) ? 1 : p_len[gp[b]];
            if (len == 1) rr[b] = (gp[b] + 1) % NP;
            else begin own[b] = gp[b]; left[b] = len - 1; end
          end else begin
            left[b]--;
            if (left[b] == 0) begin rr[b] = (own[b] + 1) % NP; own[b] = -1; end
          end
        end else if (own[b] >= 0) begin
`ifdef XBAR_LOCK_TIMEOUT_EN
          idle[b]++;
          if (idle[b] == TMO) begin
            rr[b] = (own[b] + 1) % NP; own[b] = -1; left[b] = 0; idle[b] = 0;
          end
`endif
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_ports();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int            first;
    logic [NP-1:0] exp_rdy;
    model_reset();
    idle_ports();
    for (int p = 0; p < NP; p++) g_left[p] = 0;

    // Reset state.
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    check("rst_rsp_vld", o_rvld, '0);
    check("rst_rsp_we", o_rwe, '0);
    for (int p = 0; p < NP; p++) check("rst_rsp_bank", o_rbank[p], 0);
    check("rst_req_rdy", o_rdy, '0);

    // Port0 writes a 4-beat burst to bank3.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      p_vld[0] = 1'b1; p_bank[0] = 3; p_we[0] = 1'b1; p_len[0] = 4;
      p_addr[0] = AW'(i); p_wdata[0] = {$urandom, $urandom};
      step();
      check("t1_rdy", o_rdy, 4'b0001);
      check("t1_bank_we", o_we, 8'h08);
      check("t1_addr", o_addr[3], i);
      if (i > 0) begin
        check("t1_rsp_vld", o_rvld, 4'b0001);
        check("t1_rsp_we", o_rwe[0], 1'b1);
      end
    end
    idle_ports();
    step();
    check("t1_last_rsp", o_rvld, 4'b0001);
    check("t1_last_rdata", o_rdata[0], '0);

    // Three single-beat requesters on bank5, held from reset: strict rotation.
    idle_ports();
    for (int p = 0; p < 3; p++) begin
      p_vld[p] = 1'b1; p_bank[p] = 5; p_len[p] = 1; p_addr[p] = AW'(p + 10);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      exp_rdy = NP'(1 << (i % 3));
      check("t2_rr", o_rdy, exp_rdy);
    end

    // Port1 3-beat read burst on bank2 blocks port0 until it completes.
    do_reset();
    p_vld[1] = 1'b1; p_bank[1] = 2; p_we[1] = 1'b0; p_len[1] = 3;
    step();
    check("t3_first", o_rdy, 4'b0010);
    p_vld[0] = 1'b1; p_bank[0] = 2; p_len[0] = 1;
    for (int i = 0; i < 2; i++) begin
      p_addr[1] = AW'(i + 1);
      step();
      check("t3_locked", o_rdy, 4'b0010);
    end
    p_vld[1] = 1'b0;
    step();
    check("t3_handover", o_rdy, 4'b0001);

    // Read data return path.
    do_reset();
    p_vld[2] = 1'b1; p_bank[2] = 1; p_we[2] = 1'b0; p_addr[2] = 6'd7; p_len[2] = 1;
    step();
    check("t4_rdy", o_rdy, 4'b0100);
    check("t4_rd_en", o_rd, 8'h02);
    check("t4_addr", o_addr[1], 7);
    idle_ports();
    b_rdata[1] = 64'hDEAD_BEEF;
    step();
    check("t4_rsp_vld", o_rvld, 4'b0100);
    check("t4_rsp_bank", o_rbank[2], 1);
    check("t4_rsp_rdata", o_rdata[2], 64'hDEAD_BEEF);

    // Reset in the middle of port3's burst on bank0.
    do_reset();
    p_vld[3] = 1'b1; p_bank[3] = 0; p_we[3] = 1'b1; p_len[3] = 4;
    step();
    step();
    reset = 1'b1;
    step();
    check("t5_rdy_in_reset", o_rdy, '0);
    check("t5_we_in_reset", o_we, '0);
    reset = 1'b0;
    idle_ports();
    p_vld[1] = 1'b1; p_bank[1] = 0; p_len[1] = 1;
    step();
    check("t5_no_rsp", o_rvld, '0);
    check("t5_fresh_grant", o_rdy, 4'b0010);

    // Owner stalls mid-burst while port1 waits on the same bank.
    do_reset();
    p_vld[0] = 1'b1; p_bank[0] = 4; p_we[0] = 1'b1; p_len[0] = 4;
    step();
    p_vld[0] = 1'b0;
    p_vld[1] = 1'b1; p_bank[1] = 4; p_len[1] = 1;
    first = 0;
    for (int s = 1; s <= 20; s++) begin
      step();
      if (first == 0 && o_rdy[1]) first = s;
    end
`ifdef XBAR_LOCK_TIMEOUT_EN
    check("t6_timeout_grant", first, 17);
`else
    check("t6_lock_held", first, 0);
`endif

    // Randomised traffic: each port issues whole bursts with random gaps.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset = (cyc == 1500);
      for (int p = 0; p < NP; p++) begin
        if (g_left[p] == 0) begin
          p_bank[p] = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 2) : $urandom_range(0, NB - 1);
          p_we[p] = 1'($urandom_range(0, 1));
          p_len[p] = $urandom_range(0, 5);
          g_left[p] = (p_len[p] == 0) ? 1 : p_len[p];
        end
        p_vld[p] = ($urandom_range(0, 3) != 0);
        p_addr[p] = AW'($urandom);
        p_wdata[p] = {$urandom, $urandom};
      end
      for (int b = 0; b < NB; b++) b_rdata[b] = {$urandom, $urandom};
      step();
      for (int p = 0; p < NP; p++) begin
        if (reset) g_left[p] = 0;
        else if (last_acc[p]) g_left[p]--;
      end
    end
    reset = 1'b0;
    idle_ports();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
